nn_layer_seq: RTL and testbench



---
 rtl/nn_pkg.sv | 55 +++++
 rtl/nn_mac.sv | 47 ++++
 rtl/nn_layer_seq.sv | 179 +++++++++++++++++
 tb/tb_nn_layer_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the time-multiplexed neural-network layer.
// Holds the FSM encoding, activation selectors, clog2 and the saturating activation.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MAC  = 3'd2,
    ST_BIAS = 3'd3,
    ST_DONE = 3'd4
  } nn_state_e;

  localparam logic [2:0] S_IDLE = ST_IDLE;
  localparam logic [2:0] S_LOAD = ST_LOAD;
  localparam logic [2:0] S_MAC  = ST_MAC;
  localparam logic [2:0] S_BIAS = ST_BIAS;
  localparam logic [2:0] S_DONE = ST_DONE;

  localparam int ACT_SIGNED = 0;
  localparam int ACT_RELU   = 1;

  function automatic int clog2(input int value);
    int res;
    int tmp;
    res = 0;
    tmp = value - 1;
    while (tmp > 0) begin
      res = res + 1;
      tmp = tmp >>> 1;
    end
    return res;
  endfunction

  // Clamps a wide signed value into an out_w-bit result; the caller keeps the low out_w bits.
  function automatic logic signed [63:0] sat_act(input logic signed [63:0] value,
                                                 input int out_w,
                                                 input int mode);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (mode == ACT_RELU) begin
      hi = (64'sd1 <<< out_w) - 64'sd1;
      lo = 64'sd0;
    end else begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
    end
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/nn_mac.sv
// Shared multiply-accumulate: unsigned activation times signed weight, summed at ACC_W.
// Clear has priority over enable so a neuron boundary never folds in a stray product.
module nn_mac
  import nn_pkg::*;
#(
  parameter int IN_W  = 6,
  parameter int W_W   = 6,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [IN_W-1:0]         x_i,
  input  logic signed [W_W-1:0]   w_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] w_ext;
  logic signed [ACC_W-1:0] prod;

  always_comb begin
    x_ext = {{(ACC_W-IN_W){1'b0}}, x_i};
    w_ext = {{(ACC_W-W_W){w_i[W_W-1]}}, w_i};
    prod  = x_ext * w_ext;
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/nn_layer_seq.sv
// Time-multiplexed fully-connected layer: one shared MAC walks N_OUT neurons of N_IN products,
// then bias, shift and activation fill one output slot per neuron.
module nn_layer_seq
  import nn_pkg::*;
#(
  parameter int N_IN     = 12,
  parameter int N_OUT    = 10,
  parameter int IN_W     = 6,
  parameter int W_W      = 6,
  parameter int OUT_W    = 8,
  parameter int ACC_W    = 20,
  parameter int SHIFT    = 4,
  parameter int ACT_MODE = ACT_RELU,
  localparam int N_COEF  = N_OUT * (N_IN + 1),
  localparam int ADDR_W  = (clog2(N_COEF) > 0) ? clog2(N_COEF) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  input  logic                   w_wr_en,
  input  logic [ADDR_W-1:0]      w_wr_addr,
  input  logic signed [W_W-1:0]  w_wr_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_OUT*OUT_W-1:0] out_data,
  output logic                   busy,
  output logic [2:0]             dbg_state_o
);

  localparam int IW = (clog2(N_IN) > 0) ? clog2(N_IN) : 1;
  localparam int NW = (clog2(N_OUT) > 0) ? clog2(N_OUT) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
  localparam logic [NW-1:0] N_LAST = NW'(N_OUT - 1);

  logic [2:0]              state_q, state_d;
  logic [N_IN*IN_W-1:0]    x_q, x_d;
  logic [IW-1:0]           i_q, i_d;
  logic [NW-1:0]           n_q, n_d;
  logic [OUT_W-1:0]        out_q [N_OUT];
  logic [OUT_W-1:0]        out_d [N_OUT];
  logic signed [W_W-1:0]   coef_q [N_COEF];

  logic [IN_W-1:0]         x_arr [N_IN];
  logic [ADDR_W-1:0]       rd_addr;
  logic [ADDR_W-1:0]       bias_addr;
  logic signed [W_W-1:0]   w_sel;
  logic signed [W_W-1:0]   bias_sel;
  logic                    mac_clr;
  logic                    mac_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [63:0]      r64;
  logic [OUT_W-1:0]        act_val;
  logic                    wr_ok;

  for (genvar g = 0; g < N_IN; g++) begin : g_unpack
    assign x_arr[g] = x_q[g*IN_W +: IN_W];
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_pack
    assign out_data[g*OUT_W +: OUT_W] = out_q[g];
  end

  assign rd_addr   = ADDR_W'(int'(n_q) * (N_IN + 1) + int'(i_q));
  assign bias_addr = ADDR_W'(int'(n_q) * (N_IN + 1) + N_IN);
  assign w_sel     = coef_q[rd_addr];
  assign bias_sel  = coef_q[bias_addr];

  nn_mac #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .x_i   (x_arr[i_q]),
    .w_i   (w_sel),
    .acc_o (acc)
  );

  always_comb begin
    bias_ext = {{(ACC_W-W_W){bias_sel[W_W-1]}}, bias_sel};
    sum      = acc + bias_ext;
    shifted  = sum >>> SHIFT;
    r64      = {{(64-ACC_W){shifted[ACC_W-1]}}, shifted};
    act_val  = OUT_W'(sat_act(r64, OUT_W, ACT_MODE));
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds out_data stable.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    i_d     = i_q;
    n_d     = n_q;
    out_d   = out_q;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        mac_clr = 1'b1;
        i_d     = '0;
        n_d     = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (i_q == I_LAST) begin
          state_d = S_BIAS;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_BIAS: begin
        out_d[n_q] = act_val;
        mac_clr    = 1'b1;
        i_d        = '0;
        if (n_q == N_LAST) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + 1'b1;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      i_q     <= '0;
      n_q     <= '0;
      for (int k = 0; k < N_OUT; k++) begin
        out_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      i_q     <= i_d;
      n_q     <= n_d;
      out_q   <= out_d;
    end
  end

  // Coefficients survive reset so a retrained network does not need reloading after rst.
  assign wr_ok = w_wr_en && ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                 (int'(w_wr_addr) < N_COEF);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      coef_q[w_wr_addr] <= w_wr_data;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign busy        = (state_q == S_LOAD) || (state_q == S_MAC) || (state_q == S_BIAS);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_nn_layer_seq.sv
// Bench for nn_layer_seq: three instances (ReLU/shift 0, ReLU/shift 4, signed/shift 0) share
// stimulus; a coefficient mirror and an integer model feed one expected queue per instance.
module tb_nn_layer_seq;
  import nn_pkg::*;

  localparam int N_IN   = 12;
  localparam int N_OUT  = 10;
  localparam int IN_W   = 6;
  localparam int W_W    = 6;
  localparam int OUT_W  = 8;
  localparam int N_COEF = N_OUT * (N_IN + 1);
  localparam int ADDR_W = 8;
  localparam int VW     = N_IN * IN_W;
  localparam int OW     = N_OUT * OUT_W;
  localparam int LAT    = 1 + N_OUT * (N_IN + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                  in_valid = 1'b0;
  logic [VW-1:0]         in_data = '0;
  logic                  w_wr_en = 1'b0;
  logic [ADDR_W-1:0]     w_wr_addr = '0;
  logic signed [W_W-1:0] w_wr_data = '0;
  logic                  out_ready = 1'b0;

  logic          in_ready_a, in_ready_b, in_ready_c;
  logic          out_valid_a, out_valid_b, out_valid_c;
  logic [OW-1:0] out_data_a, out_data_b, out_data_c;
  logic          busy_a, busy_b, busy_c;
  logic [2:0]    st_a, st_b, st_c;

  nn_layer_seq #(.SHIFT(0), .ACT_MODE(ACT_RELU)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .busy(busy_a), .dbg_state_o(st_a));

  nn_layer_seq #(.SHIFT(4), .ACT_MODE(ACT_RELU)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .busy(busy_b), .dbg_state_o(st_b));

  nn_layer_seq #(.SHIFT(0), .ACT_MODE(ACT_SIGNED)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .busy(busy_c), .dbg_state_o(st_c));

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_a_q[$];
  logic [OW-1:0] exp_b_q[$];
  logic [OW-1:0] exp_c_q[$];
  int coef_m [N_COEF];
  int n_cmp = 0;
  int n_bad = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] model(input logic [VW-1:0] x, input int shift, input int mode);
    logic [OW-1:0] res;
    int acc;
    logic [IN_W-1:0] xe;
    res = '0;
    for (int n = 0; n < N_OUT; n++) begin
      acc = coef_m[n*(N_IN+1) + N_IN];
      for (int i = 0; i < N_IN; i++) begin
        xe  = x[i*IN_W +: IN_W];
        acc = acc + int'(xe) * coef_m[n*(N_IN+1) + i];
      end
      acc = acc >>> shift;
      if (mode == ACT_RELU) begin
        if (acc < 0) acc = 0;
        if (acc > 255) acc = 255;
      end else begin
        if (acc < -128) acc = -128;
        if (acc > 127) acc = 127;
      end
      res[n*OUT_W +: OUT_W] = acc[OUT_W-1:0];
    end
    return res;
  endfunction

  function automatic logic [VW-1:0] splat(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < N_IN; i++) r[i*IN_W +: IN_W] = IN_W'(v);
    return r;
  endfunction

  // ---------------- driver tasks (all start and end at a falling edge) ----------------
  task automatic wr(input int addr, input int val, input bit honoured);
    w_wr_en   = 1'b1;
    w_wr_addr = ADDR_W'(addr);
    w_wr_data = W_W'(val);
    if (honoured && addr < N_COEF) coef_m[addr] = val;
    @(negedge clk);
    w_wr_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_all(input int w, input int b);
    for (int n = 0; n < N_OUT; n++)
      for (int i = 0; i <= N_IN; i++)
        wr(n*(N_IN+1) + i, (i == N_IN) ? b : w, 1'b1);
  endtask

  task automatic send(input logic [VW-1:0] x);
    in_valid = 1'b1;
    in_data  = x;
    check("in_ready idle", {in_ready_a, in_ready_b, in_ready_c}, 3'b111);
    acc_cyc = cyc + 1;
    exp_a_q.push_back(model(x, 0, ACT_RELU));
    exp_b_q.push_back(model(x, 4, ACT_RELU));
    exp_c_q.push_back(model(x, 0, ACT_SIGNED));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = VW'({$urandom, $urandom, $urandom});
    check("busy after accept", {busy_a, in_ready_a}, 2'b10);
  endtask

  task automatic recv(input string tag, input bit chk_lat, input int hold);
    int waited;
    logic [OW-1:0] ea, eb, ec;
    waited = 0;
    while (!out_valid_a && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid_a) begin
      check({tag, " timeout"}, 0, 1);
      return;
    end
    if (exp_a_q.size() == 0 || exp_b_q.size() == 0 || exp_c_q.size() == 0) begin
      check({tag, " queue empty"}, 0, 1);
      return;
    end
    ea = exp_a_q.pop_front();
    eb = exp_b_q.pop_front();
    ec = exp_c_q.pop_front();
    if (chk_lat) check({tag, " latency"}, cyc - acc_cyc, LAT);
    check({tag, " valid all"}, {out_valid_b, out_valid_c}, 2'b11);
    check({tag, " data a"}, out_data_a, ea);
    check({tag, " data b"}, out_data_b, eb);
    check({tag, " data c"}, out_data_c, ec);
    for (int k = 0; k < hold; k++) begin
      in_valid = (k == hold / 2);
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, " hold"}, {out_valid_a, in_ready_a, out_data_a}, {1'b1, 1'b0, ea});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " after xfer"}, {out_valid_a, in_ready_a, st_a}, {1'b0, 1'b1, S_IDLE});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [VW-1:0] v;
    repeat (3) @(negedge clk);
    check("reset state", {in_ready_a, out_valid_a, busy_a, st_a}, {1'b1, 1'b0, 1'b0, S_IDLE});
    check("reset out_data", out_data_a, '0);
    rst = 1'b0;
    @(negedge clk);

    // Scenario 1: unit weights, zero bias, inputs 2 -> 24 per neuron.
    load_all(1, 0);
    send(splat(2));
    check("s1 front", exp_a_q[0], {N_OUT{8'h18}});
    recv("s1", 1'b1, 0);

    // Abort mid-computation; coefficients must survive.
    send(splat(2));
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst abort", {out_valid_a, busy_a, in_ready_a, st_a}, {1'b0, 1'b0, 1'b1, S_IDLE});
    void'(exp_a_q.pop_back());
    void'(exp_b_q.pop_back());
    void'(exp_c_q.pop_back());
    send(splat(2));
    recv("s1 after rst", 1'b1, 0);

    // Back-pressure with an ignored in_valid pulse in DONE.
    send(splat(2));
    recv("bp", 1'b1, 20);
    repeat (3) @(negedge clk);
    check("bp no restart", {st_a, busy_a}, {S_IDLE, 1'b0});

    // Coefficient write during MAC is dropped; in IDLE it lands.
    send(splat(2));
    repeat (10) @(negedge clk);
    wr(0, 7, 1'b0);
    recv("mac wr drop", 1'b1, 0);
    wr(0, 7, 1'b1);
    send(splat(2));
    check("idle wr front", exp_a_q[0][7:0], 8'd36);
    recv("idle wr", 1'b1, 0);

    // Out-of-range addresses are ignored; write and accept in one cycle uses the new value.
    wr(N_COEF, 31, 1'b0);
    wr(200, -32, 1'b0);
    w_wr_en = 1'b1; w_wr_addr = ADDR_W'(1); w_wr_data = W_W'(-5);
    coef_m[1] = -5;
    send(splat(3));
    w_wr_en = 1'b0;
    recv("wr+accept", 1'b1, 0);

    // Scenario 2: saturating ReLU with shift 4.
    load_all(31, 0);
    send(splat(63));
    check("s2 max front", exp_b_q[0], {N_OUT{8'hFF}});
    recv("s2 max", 1'b1, 0);
    load_all(-32, 0);
    send(splat(63));
    check("s2 neg front", exp_b_q[0], '0);
    recv("s2 neg", 1'b1, 0);

    // Scenario 3: signed saturate on neuron 3.
    for (int i = 0; i < N_IN; i++) wr(3*(N_IN+1) + i, -1, 1'b1);
    wr(3*(N_IN+1) + N_IN, -4, 1'b1);
    send(splat(5));
    check("s3 -64", exp_c_q[0][31:24], 8'hC0);
    recv("s3 w-1", 1'b1, 0);
    for (int i = 0; i < N_IN; i++) wr(3*(N_IN+1) + i, -2, 1'b1);
    send(splat(5));
    check("s3 -124", exp_c_q[0][31:24], 8'h84);
    recv("s3 w-2", 1'b1, 0);
    for (int i = 0; i < N_IN; i++) wr(3*(N_IN+1) + i, -3, 1'b1);
    send(splat(5));
    check("s3 clamp", exp_c_q[0][31:24], 8'h80);
    recv("s3 w-3", 1'b1, 0);

    // Random coefficients and vectors.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N_COEF; k++) wr(k, int'($urandom_range(0, 63)) - 32, 1'b1);
      for (int t = 0; t < 2; t++) begin
        for (int i = 0; i < N_IN; i++) v[i*IN_W +: IN_W] = IN_W'($urandom_range(0, 63));
        send(v);
        recv("random", 1'b1, 0);
      end
    end

    check("queues drained", exp_a_q.size() + exp_b_q.size() + exp_c_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
